// File: rtl/dmi_jtag_dr_pkg.sv
// Shared types and field positions for the JTAG DTM data registers (dtmcs/dmi).
// Hardreset support is compiled in with DMI_JTAG_DR_HARDRESET_EN.
package dmi_pkg;

    typedef enum logic [1:0] {
        DtmNop   = 2'd0,
        DtmRead  = 2'd1,
        DtmWrite = 2'd2
    } dtm_op_e;

    typedef enum logic [1:0] {
        DtmSuccess = 2'd0,
        DtmFailed  = 2'd2,
        DtmBusy    = 2'd3
    } dtm_status_e;

    typedef struct packed {
        logic [13:0] zero1;
        logic        dmihardreset;
        logic        dmireset;
        logic        zero0;
        logic [2:0]  idle;
        logic [1:0]  dmistat;
        logic [5:0]  abits;
        logic [3:0]  version;
    } dtmcs_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        dtm_op_e     op;
    } dmi_req_t;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } dmi_resp_t;

    localparam int unsigned DtmcsW            = 32;
    localparam int unsigned DtmcsDmiResetBit  = 16;
    localparam int unsigned DtmcsHardResetBit = 17;
    localparam int unsigned DmiOpLsb          = 0;
    localparam int unsigned DmiDataLsb        = 2;
    localparam int unsigned DmiAddrLsb        = 34;

endpackage

// File: rtl/dmi_jtag_dr_if.sv
// DMI request/response handshake between the TCK-domain DTM and the DMI CDC.
// master = DTM side, slave = CDC side.
interface dmi_jtag_dr_if #(
    parameter int unsigned Abits = 7
);
    logic             dmi_req_valid;
    logic             dmi_req_ready;
    logic [Abits-1:0] dmi_req_addr;
    logic [31:0]      dmi_req_data;
    logic [1:0]       dmi_req_op;
    logic             dmi_resp_valid;
    logic             dmi_resp_ready;
    logic [31:0]      dmi_resp_data;
    logic [1:0]       dmi_resp_resp;

    modport master (
        output dmi_req_valid, dmi_req_addr, dmi_req_data, dmi_req_op, dmi_resp_ready,
        input  dmi_req_ready, dmi_resp_valid, dmi_resp_data, dmi_resp_resp
    );

    modport slave (
        input  dmi_req_valid, dmi_req_addr, dmi_req_data, dmi_req_op, dmi_resp_ready,
        output dmi_req_ready, dmi_resp_valid, dmi_resp_data, dmi_resp_resp
    );
endinterface

// File: rtl/dmi_jtag_dr.sv
// DTM data-register stage: DTMCS/DMI shift registers plus the DMI request FSM (TCK domain).
// Optional DTMCS hardreset when DMI_JTAG_DR_HARDRESET_EN is defined.
module dmi_jtag_dr
    import dmi_pkg::*;
#(
    parameter int unsigned Abits      = 7,
    parameter int unsigned IdleCycles = 1,
    parameter int unsigned DtmVersion = 1
) (
    input  logic              tck_i,
    input  logic              trst_i,
    input  logic              dmi_clear_i,
    input  logic              capture_i,
    input  logic              shift_i,
    input  logic              update_i,
    input  logic              tdi_i,
    input  logic              dtmcs_select_i,
    output logic              dtmcs_tdo_o,
    input  logic              dmi_select_i,
    output logic              dmi_tdo_o,
    output logic              dmi_rst_o,
    dmi_jtag_dr_if.master     dmi
);

    localparam int unsigned DmiW = Abits + 34;

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_READ       = 3'd1;
    localparam logic [2:0] ST_WAIT_READ  = 3'd2;
    localparam logic [2:0] ST_WRITE      = 3'd3;
    localparam logic [2:0] ST_WAIT_WRITE = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [1:0]        error_q, error_d;
    logic [Abits-1:0]  addr_q, addr_d;
    logic [31:0]       data_q, data_d;
    logic [DtmcsW-1:0] dtmcs_q, dtmcs_d;
    logic [DmiW-1:0]   dmi_dr_q, dmi_dr_d;
    logic              dmi_rst_q, dmi_rst_d;

    logic      dtmcs_cap, dtmcs_sh, dtmcs_upd;
    logic      dmi_cap, dmi_sh, dmi_upd;
    logic      busy_evt, resp_fire, dmireset;
    logic [1:0] cap_err;
    dtmcs_t    dtmcs_init;
    dmi_resp_t resp;
    dtm_op_e   upd_op;

    assign dtmcs_cap = capture_i & dtmcs_select_i;
    assign dtmcs_sh  = shift_i   & dtmcs_select_i;
    assign dtmcs_upd = update_i  & dtmcs_select_i;
    assign dmi_cap   = capture_i & dmi_select_i;
    assign dmi_sh    = shift_i   & dmi_select_i;
    assign dmi_upd   = update_i  & dmi_select_i;

    assign dmireset  = dtmcs_upd & dtmcs_q[DtmcsDmiResetBit];
    assign resp      = '{data: dmi.dmi_resp_data, resp: dmi.dmi_resp_resp};
    assign resp_fire = dmi.dmi_resp_ready & dmi.dmi_resp_valid;
    assign upd_op    = dtm_op_e'(dmi_dr_q[DmiOpLsb +: 2]);

    // Touching the DMI register mid-transaction is a host timing violation.
    assign busy_evt = (dmi_cap | dmi_upd) & (state_q != ST_IDLE);
    assign cap_err  = (busy_evt && error_q == 2'd0) ? DtmBusy : error_q;

    always_comb begin
        dtmcs_init         = '0;
        dtmcs_init.idle    = 3'(IdleCycles);
        dtmcs_init.dmistat = error_q;
        dtmcs_init.abits   = 6'(Abits);
        dtmcs_init.version = 4'(DtmVersion);
    end

    always_comb begin
        state_d   = state_q;
        error_d   = error_q;
        addr_d    = addr_q;
        data_d    = data_q;
        dtmcs_d   = dtmcs_q;
        dmi_dr_d  = dmi_dr_q;
        dmi_rst_d = 1'b0;

        if (dtmcs_cap)     dtmcs_d = dtmcs_init;
        else if (dtmcs_sh) dtmcs_d = {tdi_i, dtmcs_q[DtmcsW-1:1]};

        if (dmi_cap)     dmi_dr_d = {addr_q, data_q, cap_err};
        else if (dmi_sh) dmi_dr_d = {tdi_i, dmi_dr_q[DmiW-1:1]};

        if (dmireset) error_d = 2'd0;

        case (state_q)
            ST_IDLE: begin
                if (dmi_upd && error_q == 2'd0) begin
                    if (upd_op == DtmRead) begin
                        addr_d  = dmi_dr_q[DmiAddrLsb +: Abits];
                        state_d = ST_READ;
                    end else if (upd_op == DtmWrite) begin
                        addr_d  = dmi_dr_q[DmiAddrLsb +: Abits];
                        data_d  = dmi_dr_q[DmiDataLsb +: 32];
                        state_d = ST_WRITE;
                    end
                end
            end
            ST_READ:       if (dmi.dmi_req_ready) state_d = ST_WAIT_READ;
            ST_WRITE:      if (dmi.dmi_req_ready) state_d = ST_WAIT_WRITE;
            ST_WAIT_READ: begin
                if (dmi.dmi_resp_valid) begin
                    data_d  = resp.data;
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT_WRITE: if (dmi.dmi_resp_valid) state_d = ST_IDLE;
            default:       state_d = ST_IDLE;
        endcase

        // A response error beats a same-cycle dmireset; busy keeps capture consistent.
        if (resp_fire && resp.resp != 2'd0 && (error_q == 2'd0 || dmireset))
            error_d = resp.resp;
        if (busy_evt && error_q == 2'd0)
            error_d = DtmBusy;

`ifdef DMI_JTAG_DR_HARDRESET_EN
        if (dtmcs_upd && dtmcs_q[DtmcsHardResetBit]) begin
            state_d   = ST_IDLE;
            error_d   = 2'd0;
            data_d    = '0;
            dmi_rst_d = 1'b1;
        end
`endif

        if (dmi_clear_i) begin
            state_d  = ST_IDLE;
            error_d  = 2'd0;
            addr_d   = '0;
            data_d   = '0;
            dtmcs_d  = '0;
            dmi_dr_d = '0;
`ifdef DMI_JTAG_DR_HARDRESET_EN
            dmi_rst_d = 1'b1;
`else
            dmi_rst_d = 1'b0;
`endif
        end
    end

    always_ff @(posedge tck_i or posedge trst_i) begin
        if (trst_i) begin
            state_q   <= ST_IDLE;
            error_q   <= 2'd0;
            addr_q    <= '0;
            data_q    <= '0;
            dtmcs_q   <= '0;
            dmi_dr_q  <= '0;
            dmi_rst_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            error_q   <= error_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            dtmcs_q   <= dtmcs_d;
            dmi_dr_q  <= dmi_dr_d;
            dmi_rst_q <= dmi_rst_d;
        end
    end

    assign dtmcs_tdo_o        = dtmcs_q[0];
    assign dmi_tdo_o          = dmi_dr_q[0];
    assign dmi_rst_o          = dmi_rst_q;
    assign dmi.dmi_req_valid  = (state_q == ST_READ) | (state_q == ST_WRITE);
    assign dmi.dmi_resp_ready = (state_q == ST_WAIT_READ) | (state_q == ST_WAIT_WRITE);
    assign dmi.dmi_req_addr   = addr_q;
    assign dmi.dmi_req_data   = data_q;
    assign dmi.dmi_req_op     = (state_q == ST_READ)  ? DtmRead  :
                                (state_q == ST_WRITE) ? DtmWrite : DtmNop;

`ifdef DMI_JTAG_DR_HARDRESET_EN
    logic unused_dtmcs;
    assign unused_dtmcs = ^{dtmcs_q[31:18], dtmcs_q[15:1]};
`else
    logic unused_dtmcs;
    assign unused_dtmcs = ^{dtmcs_q[31:17], dtmcs_q[15:1]};
`endif

endmodule

// File: doc/dmi_jtag_dr.md
Name: dmi_jtag_dr

Overview:
- TCK-domain Debug Transport Module data-register stage sitting directly downstream of the JTAG TAP.
- Consumes the TAP's capture/shift/update strobes, TDI and DR selects.
- Implements the DTMCS (32 b) and DMI (Abits+34 b) data registers and returns their serial TDO bits to the TAP.
- Converts DMI updates into a valid/ready request toward the DMI clock-domain crossing and collects the response.

Parameters:
- Abits, 7, DMI address width; also reported in dtmcs.abits.
- IdleCycles, 1, 3-bit hint reported in dtmcs.idle.
- DtmVersion, 1, 4-bit dtmcs.version (1 = debug spec 0.13).

Ports:
- tck_i  in  1  JTAG clock; all flops on posedge.
- trst_i  in  1  reset, asynchronous, active-high.
- dmi_clear_i  in  1  synchronous clear (TAP in Test-Logic-Reset).
- capture_i, shift_i, update_i  in  1 each  DR strobes from TAP.
- tdi_i  in  1  serial data in.
- dtmcs_select_i  in  1  DTMCS instruction active.
- dtmcs_tdo_o  out  1  DTMCS shift register bit 0.
- dmi_select_i  in  1  DMIACCESS instruction active.
- dmi_tdo_o  out  1  DMI shift register bit 0.
- dmi_req_valid_o  out  1  request valid.
- dmi_req_ready_i  in  1  request accepted.
- dmi_req_addr_o  out  Abits  request address.
- dmi_req_data_o  out  32  write data.
- dmi_req_op_o  out  2  1 = read, 2 = write.
- dmi_resp_valid_i  in  1  response valid.
- dmi_resp_ready_o  out  1  response accept.
- dmi_resp_data_i  in  32  read data.
- dmi_resp_resp_i  in  2  0 = ok, 2 = failed, 3 = busy.
- dmi_rst_o  out  1  one-cycle DMI hard-reset pulse.

Behaviour:
- Reset (trst_i high, async): FSM Idle, all shift/address/data registers 0, error_q = 0, every output 0.
- dmi_clear_i has the same effect as reset, applied at the next posedge. This includes aborting an outstanding transaction.
- DTMCS register:
  - Capture loads {14'b0, 1'b0 dmihardreset, 1'b0 dmireset, 1'b0, IdleCycles[2:0], error_q, Abits[5:0], DtmVersion[3:0]}.
  - Shift: q <= {tdi_i, q[31:1]}.
  - Update with q[16] set clears error_q. With q[17] set, hardreset applies (see Optional Feature).
  - All other written fields are ignored.
- DMI register, layout {addr, data[31:0], op[1:0]}:
  - Shift is LSB-first, same rule as DTMCS.
  - Capture loads {addr_q, data_q, error_q}. If the FSM is not Idle at capture and error_q == 0, error_q becomes 3 (busy) in the same cycle and 3 is the value captured.
- FSM states: Idle, Read, WaitRead, Write, WaitWrite.
  - Idle: on update_i & dmi_select_i & error_q == 0:
    - op 1: latch addr, go to Read.
    - op 2: latch addr and data, go to Write.
    - op 0/3: no action.
    - If error_q != 0, the update is ignored.
  - Read/Write: dmi_req_valid_o = 1, with addr_q, data_q and op held stable. Move to WaitRead/WaitWrite on the cycle dmi_req_ready_i is high. Valid never drops before ready.
  - WaitRead/WaitWrite: dmi_resp_ready_o = 1. On dmi_resp_valid_i:
    - WaitRead only: data_q <= dmi_resp_data_i.
    - If dmi_resp_resp_i != 0 and error_q == 0: error_q <= dmi_resp_resp_i.
    - Go to Idle.
  - An update arriving while not Idle sets error_q = 3 (if it was 0) and is otherwise ignored.
- Latency: the update cycle registers the request; dmi_req_valid_o asserts on the next cycle.
- error_q is sticky and the first error wins. It clears only on dmireset, hardreset, dmi_clear_i or reset.
- Simultaneous dmireset and a response error: the response error wins.

Optional Feature:
- DMI_JTAG_DR_HARDRESET_EN defined:
  - A DTMCS update with bit 17 set forces the FSM to Idle, clears error_q and data_q, drops any pending valid/ready, and pulses dmi_rst_o for exactly one cycle.
  - dmi_clear_i also pulses dmi_rst_o.
- Undefined: bit 17 is ignored and dmi_rst_o is tied 0.

Decomposition:
- Package dmi_pkg holds:
  - dtm_op_e (Nop = 0, Read = 1, Write = 2).
  - dtm_status_e (Success = 0, Failed = 2, Busy = 3).
  - dtmcs_t packed struct.
  - dmi_req_t {addr, data, op} and dmi_resp_t {data, resp}.
  - Field-position localparams.
- No sub-module: both DRs and the FSM stay in one module.

Test Plan:
- Reset, then DTMCS capture and 32 shifts -> TDO stream equals 0x00001071 LSB-first.
- DMI write addr 0x10 data 0xDEADBEEF op 2 -> one cycle after update, valid with addr 0x10 / data 0xDEADBEEF / op 2. Hold ready low 5 cycles: outputs stable. Response 0 -> next capture op field 0.
- DMI read addr 0x04, response data 0x12345678 resp 0 -> next DMI capture shifts out {0x04, 0x12345678, 0}.
- Second DMI update while WaitRead -> error_q = 3 and no new request. Further updates ignored. dmireset via DTMCS then a read -> request issued, status 0.
- Response resp 2 followed by a DTMCS capture -> dmistat = 2. A later busy does not overwrite it.
- With DMI_JTAG_DR_HARDRESET_EN, DTMCS bit 17 written during Write with ready held low -> valid drops next cycle, dmi_rst_o high exactly one cycle, FSM Idle. Without the macro -> no effect.
